// File: rtl/inst_pair_unpack.sv
// Holds one fetched instruction pair and presents it to decode as up to two compacted slots.
// Define UNPACK_SINGLE_ISSUE_EN to expose only slot 0, so a pair drains one instruction per cycle.

`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif
`ifndef PC_RESET
`define PC_RESET 32'h1c00_0000
`endif

module inst_pair_unpack (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        fifo_valid,
    output logic        fifo_ready,
    input  logic [31:0] fifo_inst0,
    input  logic [31:0] fifo_inst1,
    input  logic [31:0] fifo_pc,
    input  logic [31:0] fifo_pc_next,
    input  logic [31:0] fifo_badv,
    input  logic        fifo_pc_taken,
    input  logic [6:0]  fifo_exception,
    input  logic [1:0]  fifo_excp_flag,
    input  logic [1:0]  id_take,
    output logic        id_valid0,
    output logic        id_valid1,
    output logic [31:0] id_inst0,
    output logic [31:0] id_inst1,
    output logic [31:0] id_pc0,
    output logic [31:0] id_pc1,
    output logic [31:0] id_pc_next0,
    output logic [31:0] id_pc_next1,
    output logic        id_pc_taken0,
    output logic        id_pc_taken1,
    output logic [6:0]  id_exception0,
    output logic [1:0]  id_excp_flag0,
    output logic [31:0] id_badv0
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 7;
    localparam int unsigned FLG_W = 2;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_next;
        logic            taken;
    } slot_t;

    typedef struct packed {
        logic [EXC_W-1:0] exception;
        logic [FLG_W-1:0] excp_flag;
        logic [XLEN-1:0]  badv;
    } fault_t;

    localparam slot_t SLOT_IDLE = '{
        valid:   1'b0,
        inst:    `INST_NOP,
        pc:      `PC_RESET,
        pc_next: '0,
        taken:   1'b0
    };
    localparam fault_t FAULT_NONE = '0;

    // Slot 0 always holds the oldest live instruction, so the registers are the compacted view.
    slot_t  slot0_q, slot0_d;
    slot_t  slot1_q, slot1_d;
    fault_t fault_q, fault_d;

    logic [CNT_W-1:0] held_cnt_c;
    logic [CNT_W-1:0] vis_cnt_c;
    logic [CNT_W-1:0] eff_take_c;
    logic [CNT_W-1:0] remain_c;
    logic [XLEN-1:0]  pc_plus4_c;
    logic             pair_c;
    logic             pop_c;

    // Retire accounting: decode may ask for more than is visible, only the visible part counts.
    always_comb begin
        held_cnt_c = CNT_W'(slot0_q.valid) + CNT_W'(slot1_q.valid);
`ifdef UNPACK_SINGLE_ISSUE_EN
        vis_cnt_c  = CNT_W'(slot0_q.valid);
`else
        vis_cnt_c  = held_cnt_c;
`endif
        eff_take_c = (id_take > vis_cnt_c) ? vis_cnt_c : id_take;
        remain_c   = held_cnt_c - eff_take_c;
    end

    assign fifo_ready = rstn && !flush && (remain_c == '0);
    assign pop_c      = fifo_ready && fifo_valid;

    // inst1 is live only for an aligned, fault-free pair whose inst0 falls through.
    assign pc_plus4_c = fifo_pc + XLEN'(4);
    assign pair_c     = !fifo_pc[2] && (fifo_excp_flag == '0) && (fifo_pc_next != pc_plus4_c);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        fault_d = fault_q;
        if (flush) begin
            slot0_d = SLOT_IDLE;
            slot1_d = SLOT_IDLE;
            fault_d = FAULT_NONE;
        end else if (pop_c) begin
            slot0_d = '{
                valid:   1'b1,
                inst:    fifo_inst0,
                pc:      fifo_pc,
                pc_next: pair_c ? pc_plus4_c : fifo_pc_next,
                taken:   pair_c ? 1'b0 : fifo_pc_taken
            };
            fault_d = '{
                exception: fifo_exception,
                excp_flag: fifo_excp_flag,
                badv:      fifo_badv
            };
            slot1_d = SLOT_IDLE;
            if (pair_c) begin
                slot1_d = '{
                    valid:   1'b1,
                    inst:    fifo_inst1,
                    pc:      pc_plus4_c,
                    pc_next: fifo_pc_next,
                    taken:   fifo_pc_taken
                };
            end
        end else if (remain_c == '0) begin
            slot0_d = SLOT_IDLE;
            slot1_d = SLOT_IDLE;
            fault_d = FAULT_NONE;
        end else if (eff_take_c != '0) begin
            // Only reachable with a full pair held and inst0 retired: promote inst1.
            slot0_d = slot1_q;
            slot1_d = SLOT_IDLE;
            fault_d = FAULT_NONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot0_q <= SLOT_IDLE;
            slot1_q <= SLOT_IDLE;
            fault_q <= FAULT_NONE;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            fault_q <= fault_d;
        end
    end

    assign id_valid0     = slot0_q.valid;
    assign id_inst0      = slot0_q.inst;
    assign id_pc0        = slot0_q.pc;
    assign id_pc_next0   = slot0_q.pc_next;
    assign id_pc_taken0  = slot0_q.taken;
    assign id_exception0 = fault_q.exception;
    assign id_excp_flag0 = fault_q.excp_flag;
    assign id_badv0      = fault_q.badv;

`ifdef UNPACK_SINGLE_ISSUE_EN
    assign id_valid1     = 1'b0;
    assign id_inst1      = `INST_NOP;
    assign id_pc1        = `PC_RESET;
    assign id_pc_next1   = '0;
    assign id_pc_taken1  = 1'b0;
`else
    assign id_valid1     = slot1_q.valid;
    assign id_inst1      = slot1_q.inst;
    assign id_pc1        = slot1_q.pc;
    assign id_pc_next1   = slot1_q.pc_next;
    assign id_pc_taken1  = slot1_q.taken;
`endif

endmodule

// File: tb/tb_inst_pair_unpack.sv
// Scoreboard bench for inst_pair_unpack: directed per-cycle vectors push expected observations,
// a negedge monitor pops and compares them.

`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif
`ifndef PC_RESET
`define PC_RESET 32'h1c00_0000
`endif

module tb_inst_pair_unpack;

    localparam logic [31:0] K   = 32'h1111_0000;
    localparam logic [31:0] PCR = `PC_RESET;
    localparam logic [31:0] NOP = `INST_NOP;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        fifo_valid = 1'b0;
    logic        fifo_ready;
    logic [31:0] fifo_inst0 = '0, fifo_inst1 = '0, fifo_pc = '0, fifo_pc_next = '0, fifo_badv = '0;
    logic        fifo_pc_taken = 1'b0;
    logic [6:0]  fifo_exception = '0;
    logic [1:0]  fifo_excp_flag = '0;
    logic [1:0]  id_take = '0;
    logic        id_valid0, id_valid1;
    logic [31:0] id_inst0, id_inst1, id_pc0, id_pc1, id_pc_next0, id_pc_next1;
    logic        id_pc_taken0, id_pc_taken1;
    logic [6:0]  id_exception0;
    logic [1:0]  id_excp_flag0;
    logic [31:0] id_badv0;

    inst_pair_unpack dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
        .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1),
        .fifo_pc(fifo_pc), .fifo_pc_next(fifo_pc_next), .fifo_badv(fifo_badv),
        .fifo_pc_taken(fifo_pc_taken), .fifo_exception(fifo_exception), .fifo_excp_flag(fifo_excp_flag),
        .id_take(id_take),
        .id_valid0(id_valid0), .id_valid1(id_valid1),
        .id_inst0(id_inst0), .id_inst1(id_inst1),
        .id_pc0(id_pc0), .id_pc1(id_pc1),
        .id_pc_next0(id_pc_next0), .id_pc_next1(id_pc_next1),
        .id_pc_taken0(id_pc_taken0), .id_pc_taken1(id_pc_taken1),
        .id_exception0(id_exception0), .id_excp_flag0(id_excp_flag0), .id_badv0(id_badv0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic        v0;
        logic        v1;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [31:0] pn0;
        logic [31:0] pn1;
        logic        tk0;
        logic        tk1;
        logic [1:0]  f0;
        logic [6:0]  e0;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Observations are taken mid-cycle, after inputs settle and well away from the rising edge.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("fifo_ready",    32'(fifo_ready),    32'(mon_e.rdy));
            chk("id_valid0",     32'(id_valid0),     32'(mon_e.v0));
            chk("id_valid1",     32'(id_valid1),     32'(mon_e.v1));
            chk("id_pc0",        id_pc0,             mon_e.pc0);
            chk("id_pc1",        id_pc1,             mon_e.pc1);
            chk("id_inst0",      id_inst0,           mon_e.v0 ? (mon_e.pc0 ^ K) : NOP);
            chk("id_inst1",      id_inst1,           mon_e.v1 ? (mon_e.pc1 ^ K) : NOP);
            chk("id_pc_next0",   id_pc_next0,        mon_e.pn0);
            chk("id_pc_next1",   id_pc_next1,        mon_e.pn1);
            chk("id_pc_taken0",  32'(id_pc_taken0),  32'(mon_e.tk0));
            chk("id_pc_taken1",  32'(id_pc_taken1),  32'(mon_e.tk1));
            chk("id_excp_flag0", 32'(id_excp_flag0), 32'(mon_e.f0));
            chk("id_exception0", 32'(id_exception0), 32'(mon_e.e0));
            chk("id_badv0",      id_badv0,           (mon_e.f0 != 2'b00) ? mon_e.pc0 : 32'h0);
        end
    end

    task automatic drive(input logic rs, input logic fl, input logic fv, input logic [1:0] tk,
                         input logic [31:0] pc, input logic [31:0] pn, input logic ptk,
                         input logic [1:0] flg, input logic [6:0] exc);
        @(posedge clk);
        #1;
        rstn           = rs;
        flush          = fl;
        fifo_valid     = fv;
        id_take        = tk;
        fifo_pc        = pc;
        fifo_pc_next   = pn;
        fifo_pc_taken  = ptk;
        fifo_excp_flag = flg;
        fifo_exception = exc;
        fifo_inst0     = pc ^ K;
        fifo_inst1     = (pc + 32'd4) ^ K;
        fifo_badv      = (flg != 2'b00) ? pc : 32'h0;
    endtask

    task automatic push_exp(input logic rdy, input logic v0, input logic v1,
                            input logic [31:0] pc0, input logic [31:0] pc1,
                            input logic [31:0] pn0, input logic [31:0] pn1,
                            input logic tk0, input logic tk1, input logic [1:0] f0, input logic [6:0] e0);
        exp_t e;
        e = '{rdy: rdy, v0: v0, v1: v1, pc0: pc0, pc1: pc1, pn0: pn0, pn1: pn1,
              tk0: tk0, tk1: tk1, f0: f0, e0: e0};
        sbq.push_back(e);
    endtask

    task automatic push_idle(input logic rdy);
        push_exp(rdy, 1'b0, 1'b0, PCR, PCR, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 7'h00);
    endtask

    initial begin
        // Reset held: idle outputs, no pop request even with a valid entry offered.
        drive(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 2'b00, 7'h00);                push_idle(0);
        drive(0, 0, 1, 2'd2, 32'h1c000000, 32'h1c000008, 0, 2'b00, 7'h00);  push_idle(0);
`ifdef UNPACK_SINGLE_ISSUE_EN
        drive(1, 0, 1, 2'd2, 32'h1c000000, 32'h1c000008, 0, 2'b00, 7'h00);  push_idle(1);
        drive(1, 0, 1, 2'd2, 32'h1c000010, 32'h1c000018, 0, 2'b00, 7'h00);
        push_exp(0, 1, 0, 32'h1c000000, PCR, 32'h1c000004, 32'h0, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 1, 2'd2, 32'h1c000010, 32'h1c000018, 0, 2'b00, 7'h00);
        push_exp(1, 1, 0, 32'h1c000004, PCR, 32'h1c000008, 32'h0, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 1, 2'd2, 32'h1c000020, 32'h1c000028, 0, 2'b00, 7'h00);
        push_exp(0, 1, 0, 32'h1c000010, PCR, 32'h1c000014, 32'h0, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 1, 2'd2, 32'h1c000020, 32'h1c000028, 0, 2'b00, 7'h00);
        push_exp(1, 1, 0, 32'h1c000014, PCR, 32'h1c000018, 32'h0, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 0, 2'd2, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(0, 1, 0, 32'h1c000020, PCR, 32'h1c000024, 32'h0, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 0, 2'd2, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(1, 1, 0, 32'h1c000024, PCR, 32'h1c000028, 32'h0, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 0, 2'd2, 32'h0, 32'h0, 0, 2'b00, 7'h00);                push_idle(1);
`else
        // Full pair, taken whole, then back-to-back pop of the next pair.
        drive(1, 0, 1, 2'd2, 32'h1c000000, 32'h1c000008, 0, 2'b00, 7'h00);  push_idle(1);
        drive(1, 0, 1, 2'd2, 32'h1c000010, 32'h1c000018, 0, 2'b00, 7'h00);
        push_exp(1, 1, 1, 32'h1c000000, 32'h1c000004, 32'h1c000004, 32'h1c000008, 0, 0, 2'b00, 7'h00);
        // Pair drained one at a time with compaction of inst1 into slot 0.
        drive(1, 0, 0, 2'd1, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(0, 1, 1, 32'h1c000010, 32'h1c000014, 32'h1c000014, 32'h1c000018, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 0, 2'd1, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(1, 1, 0, 32'h1c000014, PCR, 32'h1c000018, 32'h0, 0, 0, 2'b00, 7'h00);
        // Odd-word pc and fall-through prediction both leave inst0 alone.
        drive(1, 0, 1, 2'd0, 32'h1c000004, 32'h1c00000c, 0, 2'b00, 7'h00);  push_idle(1);
        drive(1, 0, 1, 2'd1, 32'h1c000000, 32'h1c000004, 1, 2'b00, 7'h00);
        push_exp(1, 1, 0, 32'h1c000004, PCR, 32'h1c00000c, 32'h0, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 1, 2'd1, 32'h1c000020, 32'h1c000028, 0, 2'b01, 7'h08);
        push_exp(1, 1, 0, 32'h1c000000, PCR, 32'h1c000004, 32'h0, 1, 0, 2'b00, 7'h00);
        // Faulted entry: single slot carrying the fault info, held while decode stalls.
        drive(1, 0, 0, 2'd0, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(0, 1, 0, 32'h1c000020, PCR, 32'h1c000028, 32'h0, 0, 0, 2'b01, 7'h08);
        drive(1, 0, 0, 2'd1, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(1, 1, 0, 32'h1c000020, PCR, 32'h1c000028, 32'h0, 0, 0, 2'b01, 7'h08);
        // Compacted inst1 is then flushed while a pop is offered.
        drive(1, 0, 1, 2'd0, 32'h1c000040, 32'h1c000048, 0, 2'b00, 7'h00);  push_idle(1);
        drive(1, 0, 0, 2'd1, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(0, 1, 1, 32'h1c000040, 32'h1c000044, 32'h1c000044, 32'h1c000048, 0, 0, 2'b00, 7'h00);
        drive(1, 1, 1, 2'd2, 32'h1c000080, 32'h1c000088, 0, 2'b00, 7'h00);
        push_exp(0, 1, 0, 32'h1c000044, PCR, 32'h1c000048, 32'h0, 0, 0, 2'b00, 7'h00);
        // Flush with a full pair held, full take and a valid FIFO entry.
        drive(1, 0, 1, 2'd0, 32'h1c000080, 32'h1c000088, 0, 2'b00, 7'h00);  push_idle(1);
        drive(1, 1, 1, 2'd2, 32'h1c0000c0, 32'h1c0000c8, 0, 2'b00, 7'h00);
        push_exp(0, 1, 1, 32'h1c000080, 32'h1c000084, 32'h1c000084, 32'h1c000088, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 0, 2'd2, 32'h0, 32'h0, 0, 2'b00, 7'h00);                push_idle(1);
        // Over-take is clamped to the valid count.
        drive(1, 0, 1, 2'd2, 32'h1c000100, 32'h1c000108, 0, 2'b00, 7'h00);  push_idle(1);
        drive(1, 0, 0, 2'd3, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(1, 1, 1, 32'h1c000100, 32'h1c000104, 32'h1c000104, 32'h1c000108, 0, 0, 2'b00, 7'h00);
        // Reset mid-pair, then a pop in the first cycle after release.
        drive(1, 0, 1, 2'd0, 32'h1c000200, 32'h1c000208, 0, 2'b00, 7'h00);  push_idle(1);
        drive(1, 0, 0, 2'd0, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(0, 1, 1, 32'h1c000200, 32'h1c000204, 32'h1c000204, 32'h1c000208, 0, 0, 2'b00, 7'h00);
        drive(0, 0, 1, 2'd2, 32'h1c000300, 32'h1c000308, 0, 2'b00, 7'h00);  push_idle(0);
        drive(1, 0, 1, 2'd0, 32'h1c000300, 32'h1c000308, 0, 2'b00, 7'h00);  push_idle(1);
        drive(1, 0, 0, 2'd2, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(1, 1, 1, 32'h1c000300, 32'h1c000304, 32'h1c000304, 32'h1c000308, 0, 0, 2'b00, 7'h00);
        drive(1, 0, 0, 2'd0, 32'h0, 32'h0, 0, 2'b00, 7'h00);                push_idle(1);
        // Predicted-taken pair: slot 0 falls through, slot 1 carries the prediction.
        drive(1, 0, 1, 2'd2, 32'h1c000400, 32'h1c000800, 1, 2'b00, 7'h00);  push_idle(1);
        drive(1, 0, 0, 2'd2, 32'h0, 32'h0, 0, 2'b00, 7'h00);
        push_exp(1, 1, 1, 32'h1c000400, 32'h1c000404, 32'h1c000404, 32'h1c000800, 0, 1, 2'b00, 7'h00);
        drive(1, 0, 0, 2'd0, 32'h0, 32'h0, 0, 2'b00, 7'h00);                push_idle(1);
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
